// File: rtl/avm_cfg_pkg.sv
// Shared types and constants for the Avalon-MM configuration master.
package avm_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int STALL_W = 8;
  localparam int LAT_W   = 3;

endpackage

// File: rtl/avm_cfg_master.sv
// Single-outstanding Avalon-MM master driven by a valid/ready command port.
// Define AVM_CFG_TIMEOUT_EN to abort transfers stalled by waitrequest.
module avm_cfg_master
  import avm_cfg_pkg::*;
#(
  parameter int ADDR_W       = 1,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_rl
    $error("READ_LATENCY must be 1..7");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_to
    $error("TIMEOUT must be 1..255");
  end

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_read;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [LAT_W-1:0]    r_lat;
  logic                w_timeout;

`ifdef AVM_CFG_TIMEOUT_EN
  localparam logic [STALL_W-1:0] TO_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0]  r_stall;
  logic                r_err;

  assign w_timeout = avm_waitrequest && (r_stall == TO_LAST);
  assign rsp_err   = r_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_lat       <= '0;
`ifdef AVM_CFG_TIMEOUT_EN
      r_stall     <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_address;
            r_wdata     <= cmd_wdata;
            r_cmd_ready <= 1'b0;
            r_write     <= (cmd_write == OP_WRITE);
            r_read      <= (cmd_write == OP_READ);
            r_state     <= (cmd_write == OP_WRITE) ? ST_WR : ST_RD;
`ifdef AVM_CFG_TIMEOUT_EN
            r_stall     <= '0;
`endif
          end
        end
        ST_WR: begin
          if (!avm_waitrequest) begin
            r_write     <= 1'b0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`ifdef AVM_CFG_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
          end else if (w_timeout) begin
            r_write     <= 1'b0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`ifdef AVM_CFG_TIMEOUT_EN
            r_err       <= 1'b1;
`endif
          end
`ifdef AVM_CFG_TIMEOUT_EN
          else r_stall <= r_stall + 1'b1;
`endif
        end
        ST_RD: begin
          if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_lat   <= LAT_LOAD;
            r_state <= ST_RD_WAIT;
          end else if (w_timeout) begin
            r_read      <= 1'b0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`ifdef AVM_CFG_TIMEOUT_EN
            r_err       <= 1'b1;
`endif
          end
`ifdef AVM_CFG_TIMEOUT_EN
          else r_stall <= r_stall + 1'b1;
`endif
        end
        ST_RD_WAIT: begin
          // Counter reaches zero on the cycle readdata is valid.
          if (r_lat == '0) begin
            r_rdata     <= avm_readdata;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`ifdef AVM_CFG_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_read      <= 1'b0;
          r_write     <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rdata;
  assign avm_address   = r_addr;
  assign avm_read      = r_read;
  assign avm_write     = r_write;
  assign avm_writedata = r_wdata;

endmodule

// File: tb/tb_avm_cfg_master.sv
// Directed bench for avm_cfg_master with a two-register slave model.
// Timeout sequence runs only when AVM_CFG_TIMEOUT_EN is defined.
module tb_avm_cfg_master;

  localparam int ADDR_W = 1;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  int n_cmp = 0;
  int n_bad = 0;

  avm_cfg_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ_LATENCY(1), .TIMEOUT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_address(cmd_address),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clock = ~clock;

  // PWM-style CSR slave: registered readdata, one cycle latency
  logic [DATA_W-1:0] s_mem [2];
  always @(posedge clock) begin
    if (reset) begin
      s_mem[0]     <= '0;
      s_mem[1]     <= '0;
      avm_readdata <= '0;
    end else begin
      if (avm_write && !avm_waitrequest)
        s_mem[avm_address] <= avm_writedata;
      if (avm_read && !avm_waitrequest)
        avm_readdata <= s_mem[avm_address];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // Issue one command; count strobe cycles and accept-to-response cycles.
  task automatic run_cmd(input vec_t v, input bit hs,
                         output int strobes, output int lat);
    bit addr_ok;
    strobes = 0;
    lat = 0;
    addr_ok = 1;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid   = 1'b1;
    cmd_write   = v.wr;
    cmd_address = v.addr;
    cmd_wdata   = v.wdata;
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 32'hFFFF_FFFF;
    while (!rsp_valid && lat < 50) begin
      if (avm_read && avm_write) addr_ok = 0;
      if (avm_read || avm_write) begin
        strobes++;
        if (avm_address !== v.addr) addr_ok = 0;
        if (v.wr && avm_writedata !== v.wdata) addr_ok = 0;
        if (v.wr != avm_write) addr_ok = 0;
      end
      avm_waitrequest = (strobes >= 1) && (strobes <= v.stall);
      tick();
      lat++;
    end
    avm_waitrequest = 1'b0;
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    check("avm_bus_stable", {31'd0, addr_ok}, 32'd1);
    check("cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
    if (hs) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    int strobes;
    int lat;
    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_address     = '0;
    cmd_wdata       = '0;
    rsp_ready       = 1'b0;
    avm_waitrequest = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0123, 0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0400, 3, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h0,         0, 32'h0000_0400};
    vecs[3] = '{1'b0, 1'b0, 32'h0,         2, 32'h0000_0123};
    vecs[4] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b1, 32'h0,         1, 32'h0000_0400};

    tick(); tick();
    check("rst_avm_read",  {31'd0, avm_read},  32'd0);
    check("rst_avm_write", {31'd0, avm_write}, 32'd0);
    check("rst_avm_addr",  {31'd0, avm_address}, 32'd0);
    check("rst_avm_wdata", avm_writedata, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    reset = 1'b0;
    tick();
    check("cmd_ready_post_rst", {31'd0, cmd_ready}, 32'd1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i], 1'b0, strobes, lat);
      check($sformatf("v%0d_strobes", i), strobes, vecs[i].stall + 1);
      check($sformatf("v%0d_latency", i), lat,
            vecs[i].wr ? vecs[i].stall + 1 : vecs[i].stall + 2);
      check($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'd0, rsp_err}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_hs", i), {31'd0, rsp_valid}, 32'd0);
    end

    // Backpressure: response held, new command ignored until handshake
    run_cmd(vecs[6], 1'b0, strobes, lat);
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_address = 1'b0;
    cmd_wdata   = 32'h0000_0055;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h0000_0400);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_no_strobe", {30'd0, avm_read, avm_write}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_after_hs_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_after_hs_nowr", {31'd0, avm_write}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp_accept_wr", {31'd0, avm_write}, 32'd1);
    check("bp_accept_data", avm_writedata, 32'h0000_0055);
    tick();
    check("bp_wr_rsp", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset while waiting for read data
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_address = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("mr_in_rd", {31'd0, avm_read}, 32'd1);
    tick();
    check("mr_in_rd_wait", {31'd0, avm_read}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_avm_read", {31'd0, avm_read}, 32'd0);
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mr_rsp_rdata", rsp_rdata, 32'd0);
    check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

`ifdef AVM_CFG_TIMEOUT_EN
    begin
      int cyc;
      strobes = 0;
      cyc = 0;
      cmd_valid   = 1'b1;
      cmd_write   = 1'b0;
      cmd_address = 1'b0;
      tick();
      cmd_valid = 1'b0;
      avm_waitrequest = 1'b1;
      while (!rsp_valid && cyc < 20) begin
        if (avm_read) strobes++;
        tick();
        cyc++;
      end
      check("to_strobes", strobes, 4);
      check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
      check("to_rsp_rdata", rsp_rdata, 32'd0);
      avm_waitrequest = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("to_back_idle", {31'd0, cmd_ready}, 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
